sequential_divider: RTL and testbench
=====================================

// Module: sequential_divider
// PURPOSE
//  Multi-cycle restoring divider; the inverse of the team's shift-add multiplier.
//  It divides an unsigned DIVIDEND_W-bit dividend by an unsigned DIVISOR_W-bit divisor.
//  One quotient bit is produced per cycle.
//  Sits beside the multiplier in the arithmetic unit with the same start/done style:
//  start pulse in, one-cycle done pulse out, results held until the next load.
// PARAMETERS
//  DIVIDEND_W  8  dividend and quotient width, in bits (>=2)
//  DIVISOR_W   4  divisor and remainder width, in bits (>=2, <=DIVIDEND_W)
// PORTS
//  clk           in   1            single clock; all state changes on rising edge
//  rst           in   1            asynchronous reset, active-low
//  start         in   1            begin a division; sampled only in IDLE
//  dividend      in   DIVIDEND_W   unsigned dividend; captured when start is accepted
//  divisor       in   DIVISOR_W    unsigned divisor; captured when start is accepted
//  quotient      out  DIVIDEND_W   registered quotient of the last completed division
//  remainder     out  DIVISOR_W    registered remainder of the last completed division
//  divByZero     out  1            high when the last completed division had divisor==0
//  quotientDone  out  1            one-cycle pulse: results are valid/updated
// BEHAVIOUR
//  Reset (rst low, async)
//   - state=IDLE.
//   - quotient, remainder, divByZero, quotientDone, iteration counter and working regs = 0.
//   - Abort mid-operation leaves no partial result.
//  State machine: IDLE, ITER, DONE.
//  IDLE, start=1 at edge, divisor!=0
//   - load working quotient Q=dividend, partial remainder R=0 (DIVISOR_W+1 bits).
//   - latch divisor D, count=0, go ITER.
//  IDLE, start=1 at edge, divisor==0
//   - skip iteration, go DONE.
//   - quotient <= all ones, remainder <= dividend[DIVISOR_W-1:0], divByZero <= 1.
//  ITER, each edge
//   - T = {R[DIVISOR_W-1:0], Q[MSB]}.
//   - If T>=D: R<=T-D, Q<={Q[MSB-1:0],1}; else R<=T, Q<={Q[MSB-1:0],0}.
//   - count++.
//   - On the edge where count==DIVIDEND_W-1: quotient<=new Q,
//     remainder<=new R[DIVISOR_W-1:0], divByZero<=0, go DONE.
//  DONE: quotientDone=1 for exactly this cycle; next edge -> IDLE unconditionally.
//  Latency
//   - Normal: start accepted at edge N -> quotientDone high in the cycle after
//     edge N+DIVIDEND_W (9 cycles for defaults).
//   - Divide by zero: high in the cycle after edge N.
//  Outputs are registered and change only on the DONE-entry edge or reset.
//  During ITER they hold the previous result.
//  start while in ITER or DONE is ignored; no queuing.
//  start held high continuously: a new division is accepted in the IDLE cycle after
//  DONE, so back-to-back throughput is one result per DIVIDEND_W+2 cycles.
//  dividend/divisor may change freely after acceptance; latched copies are used.
//  The R width of DIVISOR_W+1 prevents overflow of T; the final R is always < D.
//  quotientDone is never high in two consecutive cycles.
// TESTING
//  1 Reset: rst low with a random state -> all outputs 0, state IDLE; release -> stays
//    idle without start.
//  2 dividend=200, divisor=7, start one cycle -> quotientDone on cycle 9: quotient=28,
//    remainder=4, divByZero=0.
//  3 Boundaries: 255/15 -> q=17 r=0; 5/9 -> q=0 r=5; 0/3 -> q=0 r=0; 255/1 -> q=255 r=0.
//  4 dividend=0xA3, divisor=0 -> quotientDone 1 cycle after start: quotient=0xFF,
//    remainder=3, divByZero=1.
//  5 start pulses and operand changes during ITER of 100/6 -> ignored; result q=16 r=4;
//    single done pulse.
//  6 rst asserted mid-ITER, then start 9/2 -> outputs zeroed immediately, then q=4 r=1 at
//    the normal latency.
//  Self-check: random sweep over all 2^12 operand pairs against the golden results
//  dividend/divisor and dividend%divisor.

Source files
------------

// File: rtl/sequential_divider.sv
// ============================================================================
// Module   : sequential_divider
// Brief    : Multi-cycle restoring divider, one quotient bit per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sequential_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  divByZero,
  output logic                  quotientDone
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_iter = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [CNT_W-1:0] c_last = CNT_W'(DIVIDEND_W - 1);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  logic [1:0]            r_state;
  logic [DIVIDEND_W-1:0] r_q;
  // The partial remainder always stays below the divisor, so its extra top
  // bit is implicit: it only exists inside the trial value w_t.
  logic [DIVISOR_W-1:0]  r_r;
  logic [DIVISOR_W-1:0]  r_d;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_done;

  logic [DIVISOR_W:0]    w_t;
  logic                  w_ge;
  logic [DIVISOR_W-1:0]  w_r_next;
  logic [DIVIDEND_W-1:0] w_q_next;

  always_comb begin
    w_t      = {r_r, r_q[DIVIDEND_W-1]};
    w_ge     = (w_t >= {1'b0, r_d});
    w_r_next = w_ge ? DIVISOR_W'(w_t - {1'b0, r_d}) : w_t[DIVISOR_W-1:0];
    w_q_next = {r_q[DIVIDEND_W-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= c_idle;
      r_q       <= '0;
      r_r       <= '0;
      r_d       <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (start) begin
            if (divisor != '0) begin
              r_q     <= dividend;
              r_r     <= '0;
              r_d     <= divisor;
              r_cnt   <= '0;
              r_state <= c_iter;
            end else begin
              quotient  <= '1;
              remainder <= dividend[DIVISOR_W-1:0];
              divByZero <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= c_done;
            end
          end
        end
        c_iter: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt + c_one;
          if (r_cnt == c_last) begin
            quotient  <= w_q_next;
            remainder <= w_r_next;
            divByZero <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= c_done;
          end
        end
        c_done:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

  assign quotientDone = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sequential_divider.sv
// ============================================================================
// Module   : tb_sequential_divider
// Brief    : Directed and exhaustive-shuffled checks against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sequential_divider;

  localparam int DW = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [SW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          divByZero;
  logic          quotientDone;

  int n_checks = 0;
  int n_pass   = 0;
  int prev_q   = 0;
  int prev_r   = 0;
  int prev_z   = 0;

  sequential_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dividend     (dividend),
    .divisor      (divisor),
    .quotient     (quotient),
    .remainder    (remainder),
    .divByZero    (divByZero),
    .quotientDone (quotientDone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic void ref_div(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << DW) - 1;
      r = a % (1 << SW);
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction

  // Called just after a rising edge with the divider idle; returns one cycle
  // after the done pulse, again idle.
  task automatic run_div(input int a, input int b, input bit noise);
    int eq, er, ez, k;
    ref_div(a, b, eq, er, ez);
    start    = 1'b1;
    dividend = DW'(a);
    divisor  = SW'(b);
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = DW'($urandom);
    divisor  = SW'($urandom);
    k = 0;
    while (quotientDone !== 1'b1 && k < 20) begin
      chk("hold_q", 32'(quotient), 32'(prev_q));
      chk("hold_r", 32'(remainder), 32'(prev_r));
      if (noise) begin
        start    = 1'($urandom);
        dividend = DW'($urandom);
        divisor  = SW'($urandom);
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    chk("latency", 32'(k), (b == 0) ? 32'd0 : 32'(DW));
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("divByZero", 32'(divByZero), 32'(ez));
    prev_q = eq;
    prev_r = er;
    prev_z = ez;
    @(posedge clk); #1;
    chk("done_single", 32'(quotientDone), 32'd0);
  endtask

  int order [1 << (DW + SW)];

  initial begin
    int k, tmp, j;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    // Reset
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_z", 32'(divByZero), 32'd0);
    chk("rst_done", 32'(quotientDone), 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_done", 32'(quotientDone), 32'd0);
    chk("idle_q", 32'(quotient), 32'd0);

    // Directed cases and boundaries
    run_div(200, 7, 1'b0);
    run_div(255, 15, 1'b0);
    run_div(5, 9, 1'b0);
    run_div(0, 3, 1'b0);
    run_div(255, 1, 1'b0);
    run_div(8'hA3, 0, 1'b0);

    // Start pulses and operand changes while iterating are ignored
    run_div(100, 6, 1'b1);

    // Asynchronous reset in the middle of an operation
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 4'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("abort_q", 32'(quotient), 32'd0);
    chk("abort_r", 32'(remainder), 32'd0);
    chk("abort_z", 32'(divByZero), 32'd0);
    chk("abort_done", 32'(quotientDone), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    prev_q = 0;
    prev_r = 0;
    prev_z = 0;
    run_div(9, 2, 1'b0);

    // start held high: one result every DW+2 cycles
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 4'd7;
    k = 0;
    @(posedge clk); #1;
    while (quotientDone !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    k = 0;
    @(posedge clk); #1;
    k++;
    while (quotientDone !== 1'b1 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    chk("b2b_period", 32'(k), 32'(DW + 2));
    chk("b2b_q", 32'(quotient), 32'd7);
    chk("b2b_r", 32'(remainder), 32'd1);
    prev_q = 7;
    prev_r = 1;
    @(posedge clk); #1;

    // Every operand pair, in shuffled order
    for (int i = 0; i < (1 << (DW + SW)); i++) order[i] = i;
    for (int i = (1 << (DW + SW)) - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < (1 << (DW + SW)); i++)
      run_div(order[i] >> SW, order[i] % (1 << SW), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
